ctu_store: RTL and testbench
============================

Name: ctu_store

Overview:
- Storage back-end of the CTU set.
- Bundles two independent resources under one clock and reset:
  - a show-ahead circular FIFO holding entries in arrival order;
  - a dual-port bitmap RAM recording which entries are currently present.
- The CTU control logic drives both port groups directly. This block contains no set semantics of its own.

Parameters:
- entry_wd, 11: FIFO entry width.
- max_len, 128: FIFO capacity in entries (need not be a power of 2).
- len_wd, 7: width of fifo_len.
- ram_add_wd, 11: RAM address width.
- ram_data_wd, 1: RAM word width.
- ram_depth, 2048: RAM words; must be <= 2**ram_add_wd.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- fifo_rd  in  1  pop head entry.
- fifo_wr  in  1  push fifo_data_in.
- fifo_data_in  in  entry_wd  entry to push.
- fifo_data_out  out  entry_wd  current head entry, combinational.
- fifo_full  out  1  count == max_len.
- fifo_empty  out  1  count == 0.
- fifo_len  out  len_wd  entry count.
- ram_cs  in  1  RAM chip select.
- ram_rd  in  1  read strobe.
- ram_wr  in  1  write strobe.
- ram_rd_add  in  ram_add_wd  read address.
- ram_wr_add  in  ram_add_wd  write address.
- ram_wr_data  in  ram_data_wd  write data.
- ram_rd_data  out  ram_data_wd  registered read data.

Behaviour:
- Reset (rst=0, asynchronous, overrides everything):
  - FIFO: read/write pointers and count go to 0; fifo_empty=1, fifo_full=0, fifo_len=0, fifo_data_out=0.
  - RAM: every word clears to 0 and ram_rd_data=0. The set must start empty.
  - Reset asserted mid-operation discards all FIFO content and all RAM content immediately.
- FIFO:
  - Circular buffer of max_len entries. Pointers wrap from max_len-1 to 0.
  - Push accepted when fifo_wr=1 and fifo_full=0. Entry is stored at the next rising edge.
  - Pop accepted when fifo_rd=1 and fifo_empty=0. The read pointer advances at the edge.
  - fifo_data_out = storage[rd_ptr] combinationally (show-ahead), so the head is valid in the same cycle rd is asserted. It is forced to 0 while empty.
  - Write-to-read latency is 1 cycle: a push into an empty FIFO appears on fifo_data_out right after that edge.
  - Pop on empty is ignored. Push on full is ignored, even when a pop is accepted in the same cycle.
  - Pop and push both accepted in one cycle: count unchanged, both pointers advance.
  - Push and pop in the same cycle on an empty FIFO: only the push takes effect.
  - fifo_full, fifo_empty and fifo_len are derived from a registered count of width len_wd+1.
  - fifo_len carries the low len_wd bits of the count. With defaults, a full FIFO reports fifo_len=0 with fifo_full=1.
- RAM:
  - All actions require ram_cs=1; with ram_cs=0 nothing changes and ram_rd_data holds its value.
  - Write: if ram_wr=1, mem[ram_wr_add] <= ram_wr_data at the edge.
  - Read: if ram_rd=1, ram_rd_data <= mem[ram_rd_add] at the edge (1-cycle latency). With ram_rd=0, ram_rd_data holds its value.
  - Read and write may occur in the same cycle at any addresses.
  - Same-address read/write returns the OLD content (read-before-write). The CTU compensates for this externally.
  - Addresses >= ram_depth: writes are ignored and reads return 0.

Decomposition:
- Shared package holds:
  - TRUE/FALSE constants;
  - CTU_SET_LENGTH (2048) and CTU_SET_LENGTH_WD (11), which supply ram_depth and ram_add_wd;
  - default entry width and FIFO depth constants.
- The FIFO logic sits inline in ctu_store.
- One sub-module, ctu_bitmap_ram, is natural for the dual-port RAM including its async clear.

Test Plan:
- Reset then push 0x005 and 0x123 on consecutive cycles:
  - after the first edge, fifo_data_out=0x005 and fifo_len=1;
  - after the second, fifo_len=2 and the head is still 0x005;
  - pop gives head 0x123 and fifo_len=1.
- Push 128 distinct values:
  - fifo_full=1 and fifo_len=0;
  - an extra push is ignored;
  - 128 pops return the values in order with pointer wrap;
  - fifo_empty=1 at the end.
- With 3 entries, assert rd and wr together with data 0x7AA: fifo_len stays 3, the head advances, and 0x7AA is read last. On an empty FIFO with rd and wr together, only the push takes effect (fifo_len=1).
- RAM: write 1 to address 0x2A, then read 0x2A: ram_rd_data=1 one cycle later. A read of 0x2B returns 0. With ram_cs=0, a write to 0x2B has no effect.
- RAM same cycle: write 1 to 0x100 while reading 0x100 (previously 0): ram_rd_data=0; the next read gives 1.
- Assert rst low mid-stream with FIFO length 5 and RAM bit 0x2A set: immediately fifo_empty=1 and fifo_len=0; a subsequent read of 0x2A returns 0.

Source files
------------

// File: rtl/ctu_store_pkg.sv
// Shared constants for the CTU storage back-end: boolean levels, the set
// size that dimensions the bitmap RAM, and default FIFO geometry.
package ctu_store_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // The set covers 2048 possible values, one bitmap word each.
    localparam int CTU_SET_LENGTH    = 2048;
    localparam int CTU_SET_LENGTH_WD = 11;

    // Default FIFO geometry: 11-bit entries, 128 deep, 7-bit length field.
    localparam int CTU_ENTRY_WD     = 11;
    localparam int CTU_FIFO_DEPTH   = 128;
    localparam int CTU_FIFO_LEN_WD  = 7;
    localparam int CTU_RAM_DATA_WD  = 1;

endpackage

// File: rtl/ctu_store_if.sv
// Port bundle between the CTU control logic (master) and the storage
// back-end (slave): FIFO push/pop group and bitmap RAM group.
interface ctu_store_if #(
    parameter int entry_wd    = ctu_store_pkg::CTU_ENTRY_WD,
    parameter int len_wd      = ctu_store_pkg::CTU_FIFO_LEN_WD,
    parameter int ram_add_wd  = ctu_store_pkg::CTU_SET_LENGTH_WD,
    parameter int ram_data_wd = ctu_store_pkg::CTU_RAM_DATA_WD
);

    logic                   fifo_rd;
    logic                   fifo_wr;
    logic [entry_wd-1:0]    fifo_data_in;
    logic [entry_wd-1:0]    fifo_data_out;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [len_wd-1:0]      fifo_len;

    logic                   ram_cs;
    logic                   ram_rd;
    logic                   ram_wr;
    logic [ram_add_wd-1:0]  ram_rd_add;
    logic [ram_add_wd-1:0]  ram_wr_add;
    logic [ram_data_wd-1:0] ram_wr_data;
    logic [ram_data_wd-1:0] ram_rd_data;

    modport master (
        output fifo_rd, fifo_wr, fifo_data_in,
        input  fifo_data_out, fifo_full, fifo_empty, fifo_len,
        output ram_cs, ram_rd, ram_wr, ram_rd_add, ram_wr_add, ram_wr_data,
        input  ram_rd_data
    );

    modport slave (
        input  fifo_rd, fifo_wr, fifo_data_in,
        output fifo_data_out, fifo_full, fifo_empty, fifo_len,
        input  ram_cs, ram_rd, ram_wr, ram_rd_add, ram_wr_add, ram_wr_data,
        output ram_rd_data
    );

endinterface

// File: rtl/ctu_bitmap_ram.sv
// Dual-port bitmap RAM recording which set members are present. Reads are
// registered and see the content from before a same-cycle write; reset
// wipes every word so the set always starts empty.
module ctu_bitmap_ram
    import ctu_store_pkg::*;
#(
    parameter int ram_add_wd  = CTU_SET_LENGTH_WD,
    parameter int ram_data_wd = CTU_RAM_DATA_WD,
    parameter int ram_depth   = CTU_SET_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cs,
    input  logic                   rd,
    input  logic                   wr,
    input  logic [ram_add_wd-1:0]  rd_add,
    input  logic [ram_add_wd-1:0]  wr_add,
    input  logic [ram_data_wd-1:0] wr_data,
    output logic [ram_data_wd-1:0] rd_data
);

    localparam logic [ram_add_wd:0] DEPTH_LIM = (ram_add_wd+1)'(ram_depth);

    logic [ram_data_wd-1:0] mem [ram_depth];
    logic                   rd_in_range;
    logic                   wr_in_range;

    // Addresses past the populated depth read as 0 and swallow writes.
    assign rd_in_range = ({1'b0, rd_add} < DEPTH_LIM);
    assign wr_in_range = ({1'b0, wr_add} < DEPTH_LIM);

    // Array update and registered read; NBA ordering gives read-before-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ram_depth; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else if (cs) begin
            if (rd) begin
                rd_data <= rd_in_range ? mem[rd_add] : '0;
            end
            if (wr && wr_in_range) begin
                mem[wr_add] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/ctu_store.sv
// Storage back-end of the CTU set: a show-ahead circular FIFO keeping
// entries in arrival order, plus the presence bitmap RAM. Both resources
// are driven directly by the CTU control logic.
module ctu_store
    import ctu_store_pkg::*;
#(
    parameter int entry_wd    = CTU_ENTRY_WD,
    parameter int max_len     = CTU_FIFO_DEPTH,
    parameter int len_wd      = CTU_FIFO_LEN_WD,
    parameter int ram_add_wd  = CTU_SET_LENGTH_WD,
    parameter int ram_data_wd = CTU_RAM_DATA_WD,
    parameter int ram_depth   = CTU_SET_LENGTH
) (
    input  logic        clk,
    input  logic        rst,
    ctu_store_if.slave  bus
);

    localparam int                PTR_WD   = (max_len > 1) ? $clog2(max_len) : 1;
    localparam logic [PTR_WD-1:0] LAST_PTR = PTR_WD'(max_len - 1);
    localparam logic [len_wd:0]   FULL_CNT = (len_wd+1)'(max_len);

    logic [entry_wd-1:0] storage [max_len];
    logic [PTR_WD-1:0]   rd_ptr;
    logic [PTR_WD-1:0]   wr_ptr;
    logic [len_wd:0]     count;
    logic                push_ok;
    logic                pop_ok;
    logic                is_full;
    logic                is_empty;

    // Pointers step around the ring, wrapping at max_len-1 even when the
    // depth is not a power of two.
    function automatic logic [PTR_WD-1:0] next_ptr(input logic [PTR_WD-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // A push on full is refused even if a pop frees a slot this cycle; a
    // pop on empty is refused, so rd+wr on empty degenerates to a push.
    assign is_full  = (count == FULL_CNT) ? TRUE : FALSE;
    assign is_empty = (count == '0)       ? TRUE : FALSE;
    assign push_ok  = bus.fifo_wr && !is_full;
    assign pop_ok   = bus.fifo_rd && !is_empty;

    assign bus.fifo_full     = is_full;
    assign bus.fifo_empty    = is_empty;
    assign bus.fifo_len      = count[len_wd-1:0];
    assign bus.fifo_data_out = is_empty ? '0 : storage[rd_ptr];

    // Pointer and occupancy bookkeeping for accepted pushes and pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are masked by the empty flag so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage[wr_ptr] <= bus.fifo_data_in;
        end
    end

    ctu_bitmap_ram #(
        .ram_add_wd  (ram_add_wd),
        .ram_data_wd (ram_data_wd),
        .ram_depth   (ram_depth)
    ) u_bitmap_ram (
        .clk     (clk),
        .rst     (rst),
        .cs      (bus.ram_cs),
        .rd      (bus.ram_rd),
        .wr      (bus.ram_wr),
        .rd_add  (bus.ram_rd_add),
        .wr_add  (bus.ram_wr_add),
        .wr_data (bus.ram_wr_data),
        .rd_data (bus.ram_rd_data)
    );

endmodule

// File: tb/tb_ctu_store.sv
// Self-checking bench for ctu_store: directed scenarios from the CTU usage
// plus a randomized run, all compared against a queue/array reference model.
module tb_ctu_store;
    import ctu_store_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: FIFO as a queue, RAM as a bit array, last read value.
    int unsigned q[$];
    bit          mdl_mem [CTU_SET_LENGTH];
    logic        mdl_rd;

    always #5 clk = ~clk;

    ctu_store_if bus ();

    ctu_store dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Safety net in case the simulation stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [CTU_ENTRY_WD-1:0] exp_head();
        return (q.size() > 0) ? CTU_ENTRY_WD'(q[0]) : '0;
    endfunction

    function automatic logic [CTU_FIFO_LEN_WD-1:0] exp_len();
        return CTU_FIFO_LEN_WD'(q.size() % CTU_FIFO_DEPTH);
    endfunction

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < CTU_SET_LENGTH; i++) mdl_mem[i] = 1'b0;
        mdl_rd = 1'b0;
    endtask

    task automatic idle();
        bus.fifo_rd      = 1'b0;
        bus.fifo_wr      = 1'b0;
        bus.fifo_data_in = '0;
        bus.ram_cs       = 1'b0;
        bus.ram_rd       = 1'b0;
        bus.ram_wr       = 1'b0;
        bus.ram_rd_add   = '0;
        bus.ram_wr_add   = '0;
        bus.ram_wr_data  = '0;
    endtask

    // Applies the current inputs to the model, then crosses one clock edge.
    task automatic tick();
        bit pop_ok;
        bit push_ok;
        pop_ok  = bus.fifo_rd && (q.size() > 0);
        push_ok = bus.fifo_wr && (q.size() < CTU_FIFO_DEPTH);
        if (bus.ram_cs) begin
            if (bus.ram_rd) mdl_rd = mdl_mem[bus.ram_rd_add];
            if (bus.ram_wr) mdl_mem[bus.ram_wr_add] = bus.ram_wr_data[0];
        end
        if (pop_ok)  void'(q.pop_front());
        if (push_ok) q.push_back(int'(bus.fifo_data_in));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.fifo_empty); end
        vectors++; if (bus.fifo_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b expected 0", bus.fifo_full); end
        vectors++; if (bus.fifo_len !== 7'd0) begin miscompares++; $display("[TB] FAIL reset_len: got %0d expected 0", bus.fifo_len); end
        vectors++; if (bus.fifo_data_out !== 11'h000) begin miscompares++; $display("[TB] FAIL reset_head: got %h expected 000", bus.fifo_data_out); end
        vectors++; if (bus.ram_rd_data !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ram_rd: got %b expected 0", bus.ram_rd_data); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_push_pop();
        bus.fifo_wr = 1'b1; bus.fifo_data_in = 11'h005;
        tick();
        vectors++; if (bus.fifo_data_out !== 11'h005) begin miscompares++; $display("[TB] FAIL first_push_head: got %h expected 005", bus.fifo_data_out); end
        vectors++; if (bus.fifo_len !== 7'd1) begin miscompares++; $display("[TB] FAIL first_push_len: got %0d expected 1", bus.fifo_len); end
        bus.fifo_data_in = 11'h123;
        tick();
        vectors++; if (bus.fifo_len !== 7'd2) begin miscompares++; $display("[TB] FAIL second_push_len: got %0d expected 2", bus.fifo_len); end
        vectors++; if (bus.fifo_data_out !== 11'h005) begin miscompares++; $display("[TB] FAIL second_push_head: got %h expected 005", bus.fifo_data_out); end
        bus.fifo_wr = 1'b0; bus.fifo_rd = 1'b1;
        tick();
        vectors++; if (bus.fifo_data_out !== 11'h123) begin miscompares++; $display("[TB] FAIL pop_head: got %h expected 123", bus.fifo_data_out); end
        vectors++; if (bus.fifo_len !== 7'd1) begin miscompares++; $display("[TB] FAIL pop_len: got %0d expected 1", bus.fifo_len); end
        tick();
        bus.fifo_rd = 1'b0;
        vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_empty: got %b expected 1", bus.fifo_empty); end
    endtask

    task automatic test_full_wrap();
        logic [CTU_ENTRY_WD-1:0] vals [CTU_FIFO_DEPTH];
        for (int i = 0; i < CTU_FIFO_DEPTH; i++) begin
            vals[i] = CTU_ENTRY_WD'((i << 4) | $urandom_range(0, 15));
        end
        bus.fifo_wr = 1'b1;
        for (int i = 0; i < CTU_FIFO_DEPTH; i++) begin
            bus.fifo_data_in = vals[i];
            tick();
        end
        vectors++; if (bus.fifo_full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_full: got %b expected 1", bus.fifo_full); end
        vectors++; if (bus.fifo_len !== 7'd0) begin miscompares++; $display("[TB] FAIL fill_len: got %0d expected 0", bus.fifo_len); end
        bus.fifo_data_in = 11'h7FF;
        tick();
        vectors++; if (bus.fifo_full !== 1'b1 || bus.fifo_len !== 7'd0) begin miscompares++; $display("[TB] FAIL extra_push: got full=%b len=%0d expected full=1 len=0", bus.fifo_full, bus.fifo_len); end
        vectors++; if (bus.fifo_data_out !== vals[0]) begin miscompares++; $display("[TB] FAIL extra_push_head: got %h expected %h", bus.fifo_data_out, vals[0]); end
        bus.fifo_rd = 1'b1; bus.fifo_data_in = 11'h555;
        tick();
        vectors++; if (bus.fifo_len !== 7'd127 || bus.fifo_full !== 1'b0) begin miscompares++; $display("[TB] FAIL rdwr_on_full: got len=%0d full=%b expected len=127 full=0", bus.fifo_len, bus.fifo_full); end
        bus.fifo_wr = 1'b0;
        for (int i = 1; i < CTU_FIFO_DEPTH; i++) begin
            vectors++; if (bus.fifo_data_out !== vals[i]) begin miscompares++; $display("[TB] FAIL wrap_pop_%0d: got %h expected %h", i, bus.fifo_data_out, vals[i]); end
            tick();
        end
        bus.fifo_rd = 1'b0;
        vectors++; if (bus.fifo_empty !== 1'b1 || bus.fifo_data_out !== 11'h000) begin miscompares++; $display("[TB] FAIL wrap_end: got empty=%b head=%h expected empty=1 head=000", bus.fifo_empty, bus.fifo_data_out); end
    endtask

    task automatic test_simultaneous();
        logic [CTU_ENTRY_WD-1:0] seed [3];
        seed[0] = 11'h011; seed[1] = 11'h022; seed[2] = 11'h033;
        bus.fifo_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.fifo_data_in = seed[i];
            tick();
        end
        bus.fifo_rd = 1'b1; bus.fifo_data_in = 11'h7AA;
        tick();
        vectors++; if (bus.fifo_len !== 7'd3) begin miscompares++; $display("[TB] FAIL rdwr_len: got %0d expected 3", bus.fifo_len); end
        vectors++; if (bus.fifo_data_out !== 11'h022) begin miscompares++; $display("[TB] FAIL rdwr_head: got %h expected 022", bus.fifo_data_out); end
        bus.fifo_wr = 1'b0;
        tick();
        tick();
        vectors++; if (bus.fifo_data_out !== 11'h7AA || bus.fifo_len !== 7'd1) begin miscompares++; $display("[TB] FAIL rdwr_last: got head=%h len=%0d expected head=7aa len=1", bus.fifo_data_out, bus.fifo_len); end
        tick();
        vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rdwr_drain: got %b expected 1", bus.fifo_empty); end
        bus.fifo_wr = 1'b1; bus.fifo_data_in = 11'h0BB;
        tick();
        vectors++; if (bus.fifo_len !== 7'd1 || bus.fifo_data_out !== 11'h0BB) begin miscompares++; $display("[TB] FAIL rdwr_empty: got len=%0d head=%h expected len=1 head=0bb", bus.fifo_len, bus.fifo_data_out); end
        bus.fifo_wr = 1'b0;
        tick();
        bus.fifo_rd = 1'b0;
    endtask

    task automatic test_ram();
        bus.ram_cs = 1'b1; bus.ram_wr = 1'b1; bus.ram_wr_add = 11'h02A; bus.ram_wr_data = 1'b1;
        tick();
        bus.ram_wr = 1'b0; bus.ram_rd = 1'b1; bus.ram_rd_add = 11'h02A;
        tick();
        vectors++; if (bus.ram_rd_data !== 1'b1) begin miscompares++; $display("[TB] FAIL ram_read_2a: got %b expected 1", bus.ram_rd_data); end
        bus.ram_rd_add = 11'h02B;
        tick();
        vectors++; if (bus.ram_rd_data !== 1'b0) begin miscompares++; $display("[TB] FAIL ram_read_2b: got %b expected 0", bus.ram_rd_data); end
        bus.ram_cs = 1'b0; bus.ram_wr = 1'b1; bus.ram_wr_add = 11'h02B; bus.ram_rd_add = 11'h02A;
        tick();
        vectors++; if (bus.ram_rd_data !== 1'b0) begin miscompares++; $display("[TB] FAIL ram_cs_hold: got %b expected 0", bus.ram_rd_data); end
        bus.ram_cs = 1'b1; bus.ram_wr = 1'b0; bus.ram_rd_add = 11'h02B;
        tick();
        vectors++; if (bus.ram_rd_data !== 1'b0) begin miscompares++; $display("[TB] FAIL ram_cs_nowrite: got %b expected 0", bus.ram_rd_data); end
        bus.ram_rd_add = 11'h02A;
        tick();
        bus.ram_rd = 1'b0; bus.ram_rd_add = 11'h02B;
        tick();
        vectors++; if (bus.ram_rd_data !== 1'b1) begin miscompares++; $display("[TB] FAIL ram_rd_hold: got %b expected 1", bus.ram_rd_data); end
        idle();
    endtask

    task automatic test_ram_rbw();
        bus.ram_cs = 1'b1; bus.ram_wr = 1'b1; bus.ram_wr_add = 11'h100; bus.ram_wr_data = 1'b1;
        bus.ram_rd = 1'b1; bus.ram_rd_add = 11'h100;
        tick();
        vectors++; if (bus.ram_rd_data !== 1'b0) begin miscompares++; $display("[TB] FAIL rbw_old: got %b expected 0", bus.ram_rd_data); end
        bus.ram_wr = 1'b0;
        tick();
        vectors++; if (bus.ram_rd_data !== 1'b1) begin miscompares++; $display("[TB] FAIL rbw_new: got %b expected 1", bus.ram_rd_data); end
        idle();
    endtask

    task automatic test_reset_midstream();
        bus.fifo_wr = 1'b1;
        bus.ram_cs = 1'b1; bus.ram_wr = 1'b1; bus.ram_wr_add = 11'h02A; bus.ram_wr_data = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.fifo_data_in = CTU_ENTRY_WD'($urandom_range(1, 2047));
            tick();
        end
        idle();
        vectors++; if (bus.fifo_len !== 7'd5) begin miscompares++; $display("[TB] FAIL mid_prelen: got %0d expected 5", bus.fifo_len); end
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        vectors++; if (bus.fifo_empty !== 1'b1 || bus.fifo_len !== 7'd0) begin miscompares++; $display("[TB] FAIL mid_reset_fifo: got empty=%b len=%0d expected empty=1 len=0", bus.fifo_empty, bus.fifo_len); end
        vectors++; if (bus.fifo_data_out !== 11'h000) begin miscompares++; $display("[TB] FAIL mid_reset_head: got %h expected 000", bus.fifo_data_out); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        bus.ram_cs = 1'b1; bus.ram_rd = 1'b1; bus.ram_rd_add = 11'h02A;
        tick();
        vectors++; if (bus.ram_rd_data !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_ram: got %b expected 0", bus.ram_rd_data); end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            int wr_pct;
            wr_pct = (n < 300) ? 70 : 30;
            bus.fifo_wr      = ($urandom_range(0, 99) < wr_pct);
            bus.fifo_rd      = ($urandom_range(0, 99) < (100 - wr_pct));
            bus.fifo_data_in = CTU_ENTRY_WD'($urandom());
            bus.ram_cs       = ($urandom_range(0, 99) < 80);
            bus.ram_rd       = $urandom_range(0, 1) == 1;
            bus.ram_wr       = $urandom_range(0, 1) == 1;
            bus.ram_rd_add   = CTU_SET_LENGTH_WD'($urandom_range(0, 31));
            bus.ram_wr_add   = CTU_SET_LENGTH_WD'($urandom_range(0, 31));
            bus.ram_wr_data  = 1'($urandom_range(0, 1));
            tick();
            vectors++; if (bus.fifo_data_out !== exp_head()) begin miscompares++; $display("[TB] FAIL rand_head cycle %0d: got %h expected %h", n, bus.fifo_data_out, exp_head()); end
            vectors++; if (bus.fifo_len !== exp_len()) begin miscompares++; $display("[TB] FAIL rand_len cycle %0d: got %0d expected %0d", n, bus.fifo_len, exp_len()); end
            vectors++; if (bus.fifo_full !== (q.size() == CTU_FIFO_DEPTH)) begin miscompares++; $display("[TB] FAIL rand_full cycle %0d: got %b expected %b", n, bus.fifo_full, q.size() == CTU_FIFO_DEPTH); end
            vectors++; if (bus.fifo_empty !== (q.size() == 0)) begin miscompares++; $display("[TB] FAIL rand_empty cycle %0d: got %b expected %b", n, bus.fifo_empty, q.size() == 0); end
            vectors++; if (bus.ram_rd_data !== mdl_rd) begin miscompares++; $display("[TB] FAIL rand_ram cycle %0d: got %b expected %b", n, bus.ram_rd_data, mdl_rd); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_full_wrap();
        test_simultaneous();
        test_ram();
        test_ram_rbw();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
